pingpong_fmap_ctrl: RTL and testbench
=====================================

Name: pingpong_fmap_ctrl

Overview:
- Controller for the two-bank ping-pong feature-map buffer (two DUAL_SRAM banks sharing rd/wr address and write data; per-bank cs/oe/we).
- Accepts a valid/ready word stream from the producing layer and writes whole frames alternately into bank 1 and bank 2.
- Reads each completed frame out of the other bank as a valid/ready stream to the consuming layer. Producer and consumer overlap fully.

Parameters:
DATA_WIDTH, 64, word width (matches buffer data_width)
ADDR_WIDTH, 9, buffer address width
FRAME_DEPTH, 512, words per frame; 2 <= FRAME_DEPTH <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock, all logic rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  producer word valid
in_ready  out  1  block can accept word this cycle
in_data  in  DATA_WIDTH  producer word
out_valid  out  1  consumer word valid
out_ready  in  1  consumer accepts word
out_data  out  DATA_WIDTH  consumer word
out_last  out  1  marks word FRAME_DEPTH-1 of a frame
cs1_rd, oe1_rd, we1_rd, cs2_rd, oe2_rd, we2_rd  out  1 each  bank read-port controls
cs1_wr, oe1_wr, we1_wr, cs2_wr, oe2_wr, we2_wr  out  1 each  bank write-port controls
addr_rd  out  ADDR_WIDTH  shared read address
addr_wr  out  ADDR_WIDTH  shared write address
data_wr  out  DATA_WIDTH  shared write data
data1_rd, data2_rd  in  DATA_WIDTH  bank read data, valid 1 cycle after read strobe
bank_full  out  2  bit0 = bank 1 holds unread frame, bit1 = bank 2

Behaviour:
- Reset: both banks EMPTY, wr_bank = rd_bank = bank 1, all counters 0. All outputs 0, except in_ready = 1 one cycle after reset release.
- SRAM protocol:
  - Read: cs_rd=1, oe_rd=1, we_rd=0 for one cycle; data on dataN_rd next cycle.
  - Write: cs_wr=1, we_wr=1, oe_wr=0; committed at that edge.
  - we*_rd and oe*_wr are tied 0. Strobes are registered outputs.
- Bank state, per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - in_ready = 1 iff the wr_bank state is EMPTY or FILLING.
  - On handshake, register a write strobe for wr_bank: addr_wr = wr_cnt, data_wr = in_data. Write lands one cycle after the handshake.
  - wr_cnt increments. At wr_cnt == FRAME_DEPTH-1: wr_cnt -> 0, bank -> FULL, wr_bank toggles.
- Read side:
  - Issue a read when the rd_bank state is FULL or DRAINING and credit allows: (words in output buffer + reads in flight) < 2. addr_rd = rd_cnt.
  - After issuing address FRAME_DEPTH-1: bank -> EMPTY on the next edge, rd_cnt -> 0, rd_bank toggles.
- Output buffer:
  - 2-entry FIFO captures the read data one cycle after each strobe, from the bank that was read.
  - out_valid = FIFO non-empty. out_last is carried as a tag with each entry.
  - out_data holds stable while out_valid && !out_ready.
- Latency, empty pipe, FULL bank, out_ready=1: first out_valid appears 2 cycles after the FULL transition edge. Steady state is 1 word/cycle.
- Latency, input to bank FULL: FULL asserts at the edge of the last input handshake, so bank_full reflects it the next cycle.
- A write to a bank never overlaps a pending read of the same bank. Releasing the bank only after the last read strobe guarantees this.
- Both banks FULL: in_ready = 0 until the rd_bank frame finishes issuing.
- Simultaneous events: a write handshake and read issue in the same cycle always target different banks. The FULL and EMPTY transitions of different banks may coincide; both take effect.
- Reset mid-operation: all state clears immediately, strobes drop asynchronously, buffered data is discarded, and no partial frame survives.

Decomposition:
- Package pingpong_pkg: bank state enum (EMPTY, FILLING, FULL, DRAINING), bank-select constants, and the SRAM read latency constant (1).
- Sub-module fmap_skid_fifo: 2-entry FIFO of {last, data} with occupancy output for credit.
- Bank state machines and counters stay in the top module.

Test Plan:
- Fill frame, FRAME_DEPTH=4, out_ready=1: input D0..D3 back-to-back -> write strobes on bank 1 at addr 0..3, bank_full = 01, out_data D0..D3 with out_last on D3, then bank_full = 00.
- Ping-pong overlap: 3 frames of 4 words at a constant stream -> writes alternate bank1/bank2/bank1, output order is exact, and in_ready never drops.
- Backpressure: out_ready=0 for 10 cycles mid-frame -> at most 2 reads outstanding, out_data stable, no word lost or duplicated after release.
- Both banks full: out_ready=0, feed 8 words -> in_ready = 0 after word 8; it re-asserts one cycle after the bank-1 last read issue once out_ready=1.
- Wrap: FRAME_DEPTH=2**ADDR_WIDTH (512) -> addr_wr and addr_rd wrap 511 -> 0, with out_last exactly at word 511.
- Reset mid-frame: assert rst after 2 of 4 words -> all strobes 0 and bank_full = 00 asynchronously; the next frame writes from addr 0 of bank 1.

Source files
------------

// File: rtl/pingpong_fmap_ctrl_pkg.sv
// Shared types and constants for the ping-pong feature-map buffer controller.
// Bank state, bank select encoding and the SRAM read latency used for output credit.
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam logic BANK1 = 1'b0;
    localparam logic BANK2 = 1'b1;

    localparam int SRAM_RD_LATENCY = 1;

    function automatic logic accepts_words(input bank_state_e s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic holds_frame(input bank_state_e s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/fmap_skid_fifo.sv
// Two-entry output FIFO of {last, data} words read back from the banks.
// The occupancy output lets the read side keep reads plus buffered words within capacity.
module fmap_skid_fifo #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH:0] entry [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= {push_last, push_data};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head entry is never the write target while occupied, so it holds under stall.
    assign out_valid             = (count_q != 2'd0);
    assign {out_last, out_data}  = out_valid ? entry[rd_ptr] : '0;
    assign count                 = count_q;

endmodule

// File: rtl/pingpong_fmap_ctrl.sv
// Ping-pong feature-map buffer controller: frames are written alternately into two
// SRAM banks while the other bank's completed frame streams out to the consumer.
module pingpong_fmap_ctrl
    import pingpong_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 9,
    parameter int FRAME_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  cs1_rd,
    output logic                  oe1_rd,
    output logic                  we1_rd,
    output logic                  cs2_rd,
    output logic                  oe2_rd,
    output logic                  we2_rd,
    output logic                  cs1_wr,
    output logic                  oe1_wr,
    output logic                  we1_wr,
    output logic                  cs2_wr,
    output logic                  oe2_wr,
    output logic                  we2_wr,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic [DATA_WIDTH-1:0] data_wr,
    input  logic [DATA_WIDTH-1:0] data1_rd,
    input  logic [DATA_WIDTH-1:0] data2_rd,
    output logic [1:0]            bank_full
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(FRAME_DEPTH - 1);
    localparam logic [2:0]            CREDIT_LIMIT = 3'(SRAM_RD_LATENCY + 1);

    bank_state_e           bank_state     [2];
    bank_state_e           bank_state_nxt [2];
    logic                  wr_bank, wr_bank_nxt;
    logic                  rd_bank, rd_bank_nxt;
    logic [ADDR_WIDTH-1:0] wr_cnt, wr_cnt_nxt;
    logic [ADDR_WIDTH-1:0] rd_cnt, rd_cnt_nxt;
    logic                  ready_en;
    logic                  rd_last_q;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_inflight;
    logic                  fifo_valid;
    logic                  fifo_last;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;
    logic [1:0]            fifo_count;
    logic [2:0]            credit_used;

    assign in_ready    = ready_en && accepts_words(bank_state[wr_bank]);
    assign wr_fire     = in_valid && in_ready;
    assign rd_inflight = cs1_rd | cs2_rd;
    assign fifo_pop    = fifo_valid && out_ready;

    // Counting this cycle's pop keeps a full-rate stream while never overfilling the FIFO.
    assign credit_used = {1'b0, fifo_count} + {2'b0, rd_inflight} - {2'b0, fifo_pop};
    assign rd_fire     = holds_frame(bank_state[rd_bank]) && (credit_used < CREDIT_LIMIT);

    // Write and read always address different banks, so both updates can land together.
    always_comb begin
        bank_state_nxt = bank_state;
        wr_bank_nxt    = wr_bank;
        rd_bank_nxt    = rd_bank;
        wr_cnt_nxt     = wr_cnt;
        rd_cnt_nxt     = rd_cnt;
        if (wr_fire) begin
            if (wr_cnt == LAST_ADDR) begin
                bank_state_nxt[wr_bank] = FULL;
                wr_cnt_nxt              = '0;
                wr_bank_nxt             = ~wr_bank;
            end else begin
                bank_state_nxt[wr_bank] = FILLING;
                wr_cnt_nxt              = wr_cnt + 1'b1;
            end
        end
        if (rd_fire) begin
            if (rd_cnt == LAST_ADDR) begin
                bank_state_nxt[rd_bank] = EMPTY;
                rd_cnt_nxt              = '0;
                rd_bank_nxt             = ~rd_bank;
            end else begin
                bank_state_nxt[rd_bank] = DRAINING;
                rd_cnt_nxt              = rd_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wr_bank       <= BANK1;
            rd_bank       <= BANK1;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            ready_en      <= 1'b0;
        end else begin
            bank_state <= bank_state_nxt;
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            wr_cnt     <= wr_cnt_nxt;
            rd_cnt     <= rd_cnt_nxt;
            ready_en   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs1_wr    <= 1'b0;
            we1_wr    <= 1'b0;
            cs2_wr    <= 1'b0;
            we2_wr    <= 1'b0;
            addr_wr   <= '0;
            data_wr   <= '0;
            cs1_rd    <= 1'b0;
            oe1_rd    <= 1'b0;
            cs2_rd    <= 1'b0;
            oe2_rd    <= 1'b0;
            addr_rd   <= '0;
            rd_last_q <= 1'b0;
        end else begin
            cs1_wr <= wr_fire && (wr_bank == BANK1);
            we1_wr <= wr_fire && (wr_bank == BANK1);
            cs2_wr <= wr_fire && (wr_bank == BANK2);
            we2_wr <= wr_fire && (wr_bank == BANK2);
            cs1_rd <= rd_fire && (rd_bank == BANK1);
            oe1_rd <= rd_fire && (rd_bank == BANK1);
            cs2_rd <= rd_fire && (rd_bank == BANK2);
            oe2_rd <= rd_fire && (rd_bank == BANK2);
            if (wr_fire) begin
                addr_wr <= wr_cnt;
                data_wr <= in_data;
            end
            if (rd_fire) begin
                addr_rd   <= rd_cnt;
                rd_last_q <= (rd_cnt == LAST_ADDR);
            end
        end
    end

    assign we1_rd    = 1'b0;
    assign we2_rd    = 1'b0;
    assign oe1_wr    = 1'b0;
    assign oe2_wr    = 1'b0;
    assign bank_full = {holds_frame(bank_state[1]), holds_frame(bank_state[0])};

    fmap_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .push_last (rd_last_q),
        .push_data (cs2_rd ? data2_rd : data1_rd),
        .pop       (fifo_pop),
        .out_valid (fifo_valid),
        .out_last  (fifo_last),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_last  = fifo_last;
    assign out_data  = fifo_data;

endmodule

// File: tb/tb_pingpong_fmap_ctrl.sv
// Scoreboard bench for pingpong_fmap_ctrl with 4-word frames in a 4-word address space,
// so every frame also exercises the address wrap and the out_last boundary.
module tb_pingpong_fmap_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          cs1_rd, oe1_rd, we1_rd, cs2_rd, oe2_rd, we2_rd;
    logic          cs1_wr, oe1_wr, we1_wr, cs2_wr, oe2_wr, we2_wr;
    logic [AW-1:0] addr_rd;
    logic [AW-1:0] addr_wr;
    logic [DW-1:0] data_wr;
    logic [DW-1:0] data1_rd;
    logic [DW-1:0] data2_rd;
    logic [1:0]    bank_full;

    int checks   = 0;
    int failures = 0;
    int word_idx = 0;
    int rd_idx   = 0;
    int rd_issued  = 0;
    int out_popped = 0;
    int in_stalls  = 0;
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_word  = '0;

    logic [DW+AW:0] exp_wr_q [$];
    logic [DW:0]    exp_out_q [$];

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];

    pingpong_fmap_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cs1_rd(cs1_rd), .oe1_rd(oe1_rd), .we1_rd(we1_rd),
        .cs2_rd(cs2_rd), .oe2_rd(oe2_rd), .we2_rd(we2_rd),
        .cs1_wr(cs1_wr), .oe1_wr(oe1_wr), .we1_wr(we1_wr),
        .cs2_wr(cs2_wr), .oe2_wr(oe2_wr), .we2_wr(we2_wr),
        .addr_rd(addr_rd), .addr_wr(addr_wr), .data_wr(data_wr),
        .data1_rd(data1_rd), .data2_rd(data2_rd),
        .bank_full(bank_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank models: the block's registered strobes act as the SRAM input registers.
    always @(posedge clk) begin
        if (cs1_wr && we1_wr) mem1[addr_wr] <= data_wr;
        if (cs2_wr && we2_wr) mem2[addr_wr] <= data_wr;
    end
    assign data1_rd = (cs1_rd && oe1_rd) ? mem1[addr_rd] : '0;
    assign data2_rd = (cs2_rd && oe2_rd) ? mem2[addr_rd] : '0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drives one word and records where it must be written and how it must come out.
    task automatic applyStimulus(input logic [DW-1:0] d);
        int   waited = 0;
        logic accepted = 1'b0;
        logic [AW-1:0] a;
        logic b;
        in_valid = 1'b1;
        in_data  = d;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready) begin
                a = AW'(word_idx % DEPTH);
                b = ((word_idx / DEPTH) % 2) == 1;
                exp_wr_q.push_back({b, a, d});
                exp_out_q.push_back({a == AW'(DEPTH - 1), d});
                word_idx++;
                accepted = 1'b1;
            end else begin
                in_stalls++;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("in_ready_timeout", 0, 1);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_wr_q.delete();
        exp_out_q.delete();
        word_idx   = 0;
        rd_idx     = 0;
        rd_issued  = 0;
        out_popped = 0;
        prev_stall = 1'b0;
        #1;
        checkOutput("reset_ctrl_zero",
                    {cs1_rd, oe1_rd, we1_rd, cs2_rd, oe2_rd, we2_rd, cs1_wr, oe1_wr, we1_wr,
                     cs2_wr, oe2_wr, we2_wr, bank_full, out_valid, out_last, in_ready}, 0);
        checkOutput("reset_bus_zero", {addr_rd, addr_wr, data_wr, out_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk) checkOutput("in_ready_at_release", in_ready, 0);
        @(negedge clk) checkOutput("in_ready_after_release", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_out_q.size() != 0 || exp_wr_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_complete", exp_out_q.size() + exp_wr_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: write/read strobe sequence, outstanding reads, output hold and order.
    always @(negedge clk) begin
        logic [DW+AW:0] wexp;
        logic [DW:0]    oexp;
        if (!rst) begin
            if (cs1_wr || cs2_wr) begin
                checkOutput("wr_ctrl", {we1_wr, we2_wr, oe1_wr, oe2_wr, we1_rd, we2_rd},
                            {cs1_wr, cs2_wr, 4'b0000});
                if (exp_wr_q.size() == 0) begin
                    checkOutput("wr_unexpected", 1, 0);
                end else begin
                    wexp = exp_wr_q.pop_front();
                    checkOutput("wr_bank_addr_data", {cs2_wr, addr_wr, data_wr}, wexp);
                end
            end
            if (cs1_rd || cs2_rd) begin
                rd_issued++;
                checkOutput("rd_ctrl", {oe1_rd, oe2_rd, cs1_rd & cs2_rd}, {cs1_rd, cs2_rd, 1'b0});
                checkOutput("rd_bank_addr", {cs2_rd, addr_rd},
                            {((rd_idx / DEPTH) % 2) == 1, AW'(rd_idx % DEPTH)});
                checkOutput("rd_outstanding_le2", (rd_issued - out_popped) <= 2, 1);
                rd_idx++;
            end
            if (prev_stall) begin
                checkOutput("out_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            end
            if (out_valid && out_ready) begin
                out_popped++;
                if (exp_out_q.size() == 0) begin
                    checkOutput("out_unexpected", 1, 0);
                end else begin
                    oexp = exp_out_q.pop_front();
                    checkOutput("out_last_data", {out_last, out_data}, oexp);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    initial begin
        int   n;
        int   seen_cyc;
        logic done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(16'hA000 + i));
        @(negedge clk);
        checkOutput("fill_bank_full", bank_full, 2'b01);
        checkOutput("first_out_valid_c0", out_valid, 0);
        @(negedge clk) checkOutput("first_out_valid_c1", out_valid, 0);
        @(negedge clk) checkOutput("first_out_valid_c2", out_valid, 1);
        waitDrain();
        @(negedge clk) checkOutput("fill_bank_empty", bank_full, 2'b00);
        @(posedge clk);
        #1;

        $display("[TB] ping-pong overlap");
        doReset();
        in_stalls = 0;
        for (int i = 0; i < 3 * DEPTH; i++) applyStimulus(DW'(16'hB000 + i * 3));
        checkOutput("pingpong_no_in_stall", in_stalls, 0);
        waitDrain();

        $display("[TB] backpressure");
        fork
            begin
                for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(DW'($urandom_range(0, 16'hFFFF)));
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] both banks full");
        out_ready = 1'b0;
        doReset();
        for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(DW'(16'hC000 + i));
        @(negedge clk) checkOutput("both_full_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        n        = 0;
        seen_cyc = -10;
        done     = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            if (cs1_rd && addr_rd == AW'(DEPTH - 1)) seen_cyc = n;
            if (in_ready) begin
                checkOutput("both_full_reassert", (seen_cyc >= 0) && (n - seen_cyc <= 1), 1);
                done = 1'b1;
            end
            n++;
        end
        if (!done) checkOutput("both_full_reassert_timeout", 0, 1);
        waitDrain();

        $display("[TB] reset mid-frame");
        doReset();
        applyStimulus(16'hD000);
        applyStimulus(16'hD001);
        checkOutput("pre_reset_wr_strobe", cs1_wr, 1);
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(16'hE000 + i));
        waitDrain();
        checkOutput("final_bank_full", bank_full, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
